// File: rtl/roce_pkg.sv
// Shared RoCEv2 TX definitions: BTH opcodes, PSN width, PMTU sizes
// and the opcode selector used by the write scheduler.
package roce_pkg;

    localparam int BTH_PSN_WIDTH = 24;

    localparam int unsigned PMTU_256  = 256;
    localparam int unsigned PMTU_512  = 512;
    localparam int unsigned PMTU_1024 = 1024;
    localparam int unsigned PMTU_2048 = 2048;
    localparam int unsigned PMTU_4096 = 4096;

    localparam logic [7:0] OP_SEND_FIRST     = 8'h00;
    localparam logic [7:0] OP_SEND_MIDDLE    = 8'h01;
    localparam logic [7:0] OP_SEND_LAST      = 8'h02;
    localparam logic [7:0] OP_SEND_LAST_IMM  = 8'h03;
    localparam logic [7:0] OP_SEND_ONLY      = 8'h04;
    localparam logic [7:0] OP_SEND_ONLY_IMM  = 8'h05;
    localparam logic [7:0] OP_WRITE_FIRST    = 8'h06;
    localparam logic [7:0] OP_WRITE_MIDDLE   = 8'h07;
    localparam logic [7:0] OP_WRITE_LAST     = 8'h08;
    localparam logic [7:0] OP_WRITE_LAST_IMM = 8'h09;
    localparam logic [7:0] OP_WRITE_ONLY     = 8'h0A;
    localparam logic [7:0] OP_WRITE_ONLY_IMM = 8'h0B;

    typedef enum logic {
        S_IDLE,
        S_ISSUE
    } sched_state_t;

    function automatic logic [7:0] op_sel(
        input logic wr,
        input logic first,
        input logic last,
        input logic imm
    );
        logic [7:0] op;
        op = 8'h00;
        unique case ({first, last})
            2'b10: op = wr ? OP_WRITE_FIRST : OP_SEND_FIRST;
            2'b00: op = wr ? OP_WRITE_MIDDLE : OP_SEND_MIDDLE;
            2'b01: begin
                if (wr) op = imm ? OP_WRITE_LAST_IMM : OP_WRITE_LAST;
                else    op = imm ? OP_SEND_LAST_IMM : OP_SEND_LAST;
            end
            2'b11: begin
                if (wr) op = imm ? OP_WRITE_ONLY_IMM : OP_WRITE_ONLY;
                else    op = imm ? OP_SEND_ONLY_IMM : OP_SEND_ONLY;
            end
            default: op = 8'h00;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/roce_tx_wr_scheduler.sv
// Splits one RDMA WRITE/SEND transfer into PMTU-sized per-packet
// descriptors (opcode, PSN, address, length) for the TX header builder.
module roce_tx_wr_scheduler
    import roce_pkg::*;
#(
    parameter int unsigned PMTU      = PMTU_2048,
    parameter int          PSN_WIDTH = BTH_PSN_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_transfer,
    input  logic [31:0]          dma_length,
    input  logic [31:0]          r_key,
    input  logic [23:0]          rem_qpn,
    input  logic [PSN_WIDTH-1:0] loc_psn,
    input  logic [63:0]          rem_addr,
    input  logic                 is_immediate,
    input  logic                 tx_type,
    output logic                 m_wr_valid,
    input  logic                 m_wr_ready,
    output logic [7:0]           m_wr_opcode,
    output logic [PSN_WIDTH-1:0] m_wr_psn,
    output logic [23:0]          m_wr_qpn,
    output logic [31:0]          m_wr_r_key,
    output logic [63:0]          m_wr_addr,
    output logic [31:0]          m_wr_dma_len,
    output logic [12:0]          m_wr_pkt_len,
    output logic                 m_wr_last,
    output logic [PSN_WIDTH-1:0] next_psn,
    output logic                 busy,
    output logic                 done
);

    localparam logic [31:0] PMTU32 = 32'(PMTU);

    sched_state_t state_q, state_d;

    logic                 start_q;
    logic [PSN_WIDTH-1:0] shadow_psn;
    logic [31:0]          rem_q;
    logic                 wr_q;
    logic                 imm_q;

    logic                 accept, adv, fin;
    logic [PSN_WIDTH-1:0] first_psn;
    logic [31:0]          c_rem;
    logic [PSN_WIDTH-1:0] c_psn;
    logic [63:0]          c_addr;
    logic                 c_wr, c_imm, c_last;
    logic [12:0]          c_len;
    logic [7:0]           c_op;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        adv     = 1'b0;
        fin     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_transfer && !start_q && !done) begin
                    accept  = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (m_wr_valid && m_wr_ready) begin
                    if (m_wr_last) begin
                        fin     = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A changed loc_psn means the QP was (re)opened; otherwise continue
    // the PSN sequence left by the previous transfer.
    assign first_psn = (loc_psn != shadow_psn) ? loc_psn : next_psn;

    always_comb begin
        c_rem  = accept ? dma_length : rem_q - PMTU32;
        c_psn  = accept ? first_psn : m_wr_psn + 1'b1;
        c_addr = accept ? rem_addr : m_wr_addr + 64'(PMTU);
        c_wr   = accept ? tx_type : wr_q;
        c_imm  = accept ? is_immediate : imm_q;
        c_last = (c_rem <= PMTU32);
        c_len  = c_last ? c_rem[12:0] : 13'(PMTU);
        c_op   = op_sel(c_wr, accept, c_last, c_imm);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q      <= 1'b0;
            shadow_psn   <= '0;
            next_psn     <= '0;
            rem_q        <= '0;
            wr_q         <= 1'b0;
            imm_q        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            m_wr_valid   <= 1'b0;
            m_wr_opcode  <= '0;
            m_wr_psn     <= '0;
            m_wr_qpn     <= '0;
            m_wr_r_key   <= '0;
            m_wr_addr    <= '0;
            m_wr_dma_len <= '0;
            m_wr_pkt_len <= '0;
            m_wr_last    <= 1'b0;
        end else begin
            start_q <= start_transfer;
            done    <= fin;
            if (accept) begin
                busy         <= 1'b1;
                wr_q         <= tx_type;
                imm_q        <= is_immediate;
                m_wr_qpn     <= rem_qpn;
                m_wr_r_key   <= r_key;
                m_wr_dma_len <= dma_length;
                if (loc_psn != shadow_psn) shadow_psn <= loc_psn;
            end
            if (accept || adv) begin
                m_wr_valid   <= 1'b1;
                rem_q        <= c_rem;
                m_wr_opcode  <= c_op;
                m_wr_psn     <= c_psn;
                m_wr_addr    <= c_addr;
                m_wr_pkt_len <= c_len;
                m_wr_last    <= c_last;
            end
            if (fin) begin
                m_wr_valid <= 1'b0;
                busy       <= 1'b0;
                next_psn   <= m_wr_psn + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_roce_tx_wr_scheduler.sv
// Directed bench for roce_tx_wr_scheduler: vector table of whole
// transfers plus stall/re-start and mid-transfer reset sequences.
module tb_roce_tx_wr_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_transfer;
    logic [31:0] dma_length;
    logic [31:0] r_key;
    logic [23:0] rem_qpn;
    logic [23:0] loc_psn;
    logic [63:0] rem_addr;
    logic        is_immediate;
    logic        tx_type;
    logic        m_wr_valid;
    logic        m_wr_ready;
    logic [7:0]  m_wr_opcode;
    logic [23:0] m_wr_psn;
    logic [23:0] m_wr_qpn;
    logic [31:0] m_wr_r_key;
    logic [63:0] m_wr_addr;
    logic [31:0] m_wr_dma_len;
    logic [12:0] m_wr_pkt_len;
    logic        m_wr_last;
    logic [23:0] next_psn;
    logic        busy;
    logic        done;

    roce_tx_wr_scheduler dut (
        .clk(clk), .rst(rst),
        .start_transfer(start_transfer),
        .dma_length(dma_length), .r_key(r_key),
        .rem_qpn(rem_qpn), .loc_psn(loc_psn),
        .rem_addr(rem_addr), .is_immediate(is_immediate),
        .tx_type(tx_type),
        .m_wr_valid(m_wr_valid), .m_wr_ready(m_wr_ready),
        .m_wr_opcode(m_wr_opcode), .m_wr_psn(m_wr_psn),
        .m_wr_qpn(m_wr_qpn), .m_wr_r_key(m_wr_r_key),
        .m_wr_addr(m_wr_addr), .m_wr_dma_len(m_wr_dma_len),
        .m_wr_pkt_len(m_wr_pkt_len), .m_wr_last(m_wr_last),
        .next_psn(next_psn), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic        imm;
        logic [31:0] len;
        logic [23:0] loc;
        logic [63:0] addr;
        logic [3:0]  n;
        logic [23:0] nxt;
    } xfer_t;

    typedef struct packed {
        logic [7:0]  op;
        logic [23:0] psn;
        logic [63:0] addr;
        logic [12:0] len;
        logic        last;
    } desc_t;

    xfer_t xt[6];
    desc_t ed[10];
    desc_t sq[3];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_desc(input string nm, input desc_t d,
                            input logic [23:0] qpn, input logic [31:0] rk,
                            input logic [31:0] dl);
        chk({nm, ".valid"}, 64'(m_wr_valid), 64'd1);
        chk({nm, ".op"}, 64'(m_wr_opcode), 64'(d.op));
        chk({nm, ".psn"}, 64'(m_wr_psn), 64'(d.psn));
        chk({nm, ".addr"}, m_wr_addr, d.addr);
        chk({nm, ".plen"}, 64'(m_wr_pkt_len), 64'(d.len));
        chk({nm, ".last"}, 64'(m_wr_last), 64'(d.last));
        chk({nm, ".qpn"}, 64'(m_wr_qpn), 64'(qpn));
        chk({nm, ".rkey"}, 64'(m_wr_r_key), 64'(rk));
        chk({nm, ".dlen"}, 64'(m_wr_dma_len), 64'(dl));
        chk({nm, ".busy"}, 64'(busy), 64'd1);
        chk({nm, ".done"}, 64'(done), 64'd0);
    endtask

    task automatic drive(input logic wr, input logic imm,
                         input logic [31:0] len, input logic [23:0] loc,
                         input logic [63:0] addr, input logic [23:0] qpn,
                         input logic [31:0] rk);
        tx_type        = wr;
        is_immediate   = imm;
        dma_length     = len;
        loc_psn        = loc;
        rem_addr       = addr;
        rem_qpn        = qpn;
        r_key          = rk;
        start_transfer = 1'b1;
    endtask

    task automatic run_case(input int ci, input int base);
        int k;
        int cyc;
        xfer_t v;
        v = xt[ci];
        @(negedge clk);
        m_wr_ready = 1'b1;
        drive(v.wr, v.imm, v.len, v.loc, v.addr,
              24'h0A0000 + 24'(ci), 32'hBEEF0000 + 32'(ci));
        k = 0;
        cyc = 0;
        while (k < int'(v.n) && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (m_wr_valid) begin
                chk_desc($sformatf("c%0d.p%0d", ci, k), ed[base + k],
                         24'h0A0000 + 24'(ci), 32'hBEEF0000 + 32'(ci),
                         v.len);
                k++;
            end
        end
        chk($sformatf("c%0d.count", ci), 64'(k), 64'(v.n));
        @(negedge clk);
        chk($sformatf("c%0d.done", ci), 64'(done), 64'd1);
        chk($sformatf("c%0d.busy", ci), 64'(busy), 64'd0);
        chk($sformatf("c%0d.vld", ci), 64'(m_wr_valid), 64'd0);
        chk($sformatf("c%0d.nxt", ci), 64'(next_psn), 64'(v.nxt));
        start_transfer = 1'b0;
    endtask

    initial begin
        int base;
        rst            = 1'b1;
        start_transfer = 1'b0;
        m_wr_ready     = 1'b0;
        dma_length     = '0;
        r_key          = '0;
        rem_qpn        = '0;
        loc_psn        = '0;
        rem_addr       = '0;
        is_immediate   = 1'b0;
        tx_type        = 1'b0;

        xt[0] = '{wr:1'b1, imm:1'b0, len:32'd100, loc:24'h10,
                  addr:64'h0, n:4'd1, nxt:24'h11};
        xt[1] = '{wr:1'b1, imm:1'b0, len:32'd5000, loc:24'h10,
                  addr:64'h1000, n:4'd3, nxt:24'h14};
        xt[2] = '{wr:1'b0, imm:1'b1, len:32'd4096, loc:24'hFFFFFF,
                  addr:64'h2000, n:4'd2, nxt:24'h1};
        xt[3] = '{wr:1'b1, imm:1'b0, len:32'd0, loc:24'hFFFFFF,
                  addr:64'h3000, n:4'd1, nxt:24'h2};
        xt[4] = '{wr:1'b0, imm:1'b0, len:32'd2049, loc:24'h500,
                  addr:64'hFFFF_FFFF_FFFF_FC00, n:4'd2, nxt:24'h502};
        xt[5] = '{wr:1'b1, imm:1'b1, len:32'd2048, loc:24'h500,
                  addr:64'h4000, n:4'd1, nxt:24'h503};

        ed[0] = '{op:8'h0A, psn:24'h10, addr:64'h0, len:13'd100, last:1'b1};
        ed[1] = '{op:8'h06, psn:24'h11, addr:64'h1000, len:13'd2048, last:1'b0};
        ed[2] = '{op:8'h07, psn:24'h12, addr:64'h1800, len:13'd2048, last:1'b0};
        ed[3] = '{op:8'h08, psn:24'h13, addr:64'h2000, len:13'd904, last:1'b1};
        ed[4] = '{op:8'h00, psn:24'hFFFFFF, addr:64'h2000, len:13'd2048, last:1'b0};
        ed[5] = '{op:8'h03, psn:24'h0, addr:64'h2800, len:13'd2048, last:1'b1};
        ed[6] = '{op:8'h0A, psn:24'h1, addr:64'h3000, len:13'd0, last:1'b1};
        ed[7] = '{op:8'h00, psn:24'h500, addr:64'hFFFF_FFFF_FFFF_FC00,
                  len:13'd2048, last:1'b0};
        ed[8] = '{op:8'h02, psn:24'h501, addr:64'h400, len:13'd1, last:1'b1};
        ed[9] = '{op:8'h0B, psn:24'h502, addr:64'h4000, len:13'd2048, last:1'b1};

        sq[0] = '{op:8'h06, psn:24'h600, addr:64'h8000, len:13'd2048, last:1'b0};
        sq[1] = '{op:8'h07, psn:24'h601, addr:64'h8800, len:13'd2048, last:1'b0};
        sq[2] = '{op:8'h08, psn:24'h602, addr:64'h9000, len:13'd904, last:1'b1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst.valid", 64'(m_wr_valid), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.nxt", 64'(next_psn), 64'd0);
        chk("rst.psn", 64'(m_wr_psn), 64'd0);
        chk("rst.op", 64'(m_wr_opcode), 64'd0);

        base = 0;
        for (int i = 0; i < 6; i++) begin
            run_case(i, base);
            base += int'(xt[i].n);
        end

        // stall with ready low and a second start edge while busy
        @(negedge clk);
        m_wr_ready = 1'b1;
        drive(1'b1, 1'b0, 32'd5000, 24'h600, 64'h8000, 24'h000777, 32'hCAFE0001);
        @(negedge clk);
        chk_desc("st.p0", sq[0], 24'h000777, 32'hCAFE0001, 32'd5000);
        @(negedge clk);
        chk_desc("st.p1", sq[1], 24'h000777, 32'hCAFE0001, 32'd5000);
        m_wr_ready = 1'b0;
        start_transfer = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_desc($sformatf("st.hold%0d", i), sq[1],
                     24'h000777, 32'hCAFE0001, 32'd5000);
            if (i == 1) begin
                start_transfer = 1'b1;
                loc_psn = 24'h123;
                dma_length = 32'd64;
            end
        end
        m_wr_ready = 1'b1;
        @(negedge clk);
        chk_desc("st.p2", sq[2], 24'h000777, 32'hCAFE0001, 32'd5000);
        @(negedge clk);
        chk("st.done", 64'(done), 64'd1);
        chk("st.busy", 64'(busy), 64'd0);
        chk("st.nxt", 64'(next_psn), 64'h603);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("st.idle%0d", i), 64'(m_wr_valid), 64'd0);
            chk($sformatf("st.nodone%0d", i), 64'(done), 64'd0);
        end
        start_transfer = 1'b0;

        // reset during packet 2 of 3
        @(negedge clk);
        m_wr_ready = 1'b1;
        drive(1'b1, 1'b0, 32'd5000, 24'h700, 64'h0, 24'h000888, 32'hCAFE0002);
        @(negedge clk);
        chk("rs.p0psn", 64'(m_wr_psn), 64'h700);
        @(negedge clk);
        chk("rs.p1psn", 64'(m_wr_psn), 64'h701);
        start_transfer = 1'b0;
        m_wr_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rs.valid", 64'(m_wr_valid), 64'd0);
        chk("rs.busy", 64'(busy), 64'd0);
        chk("rs.done", 64'(done), 64'd0);
        chk("rs.nxt", 64'(next_psn), 64'd0);
        @(negedge clk);
        chk("rs.done2", 64'(done), 64'd0);
        m_wr_ready = 1'b1;
        drive(1'b1, 1'b0, 32'd100, 24'h700, 64'h40, 24'h000999, 32'hCAFE0003);
        @(negedge clk);
        chk_desc("rs.new", '{op:8'h0A, psn:24'h700, addr:64'h40,
                             len:13'd100, last:1'b1},
                 24'h000999, 32'hCAFE0003, 32'd100);
        @(negedge clk);
        chk("rs.newdone", 64'(done), 64'd1);
        chk("rs.newnxt", 64'(next_psn), 64'h701);
        start_transfer = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
